seq_divider: RTL and testbench

- Multi-cycle, parametrised non-restoring divider for the ALU divide path; replaces the single-cycle combinational divider.
- Computes one quotient bit per clock, adds signed/unsigned mode and divide-by-zero detection, and uses a start/done handshake.
- Result packing is unchanged for the HI/LO register load: quotient in the upper half, remainder in the lower half.

---
 rtl/seq_divider.sv | 151 +++++++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring divider: one quotient bit per clock, signed/unsigned
// operands, divide-by-zero detection, start/done handshake, {quotient, remainder} result.
module seq_divider #(
    parameter int BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [BITS-1:0]   dividend,
    input  logic [BITS-1:0]   divisor,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [2*BITS-1:0] result
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t              state_q, state_d;
    logic [BITS:0]       a_q, a_d;
    logic [BITS-1:0]     q_q, q_d;
    logic [BITS-1:0]     m_q, m_d;
    logic [CW-1:0]       count_q, count_d;
    logic                neg_n_q, neg_n_d;
    logic                neg_d_q, neg_d_d;
    logic                zero_q, zero_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic [2*BITS-1:0]   result_q, result_d;

    logic [BITS:0]       a_sh;
    logic [BITS:0]       a_step;
    logic [BITS-1:0]     rem_mag;
    logic [BITS-1:0]     quo;
    logic [BITS-1:0]     rem;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        count_d  = count_q;
        neg_n_d  = neg_n_q;
        neg_d_d  = neg_d_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        result_d = result_q;
        a_sh     = '0;
        a_step   = '0;
        rem_mag  = '0;
        quo      = '0;
        rem      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_n_d = signed_mode & dividend[BITS-1];
                    neg_d_d = signed_mode & divisor[BITS-1];
                    a_d     = '0;
                    count_d = '0;
                    if (divisor == '0) begin
                        // Keep the raw dividend in Q so it can be returned as the remainder.
                        zero_d  = 1'b1;
                        q_d     = dividend;
                        m_d     = '0;
                        state_d = S_FIX;
                    end else begin
                        zero_d  = 1'b0;
                        q_d     = (signed_mode && dividend[BITS-1]) ? -dividend : dividend;
                        m_d     = (signed_mode && divisor[BITS-1])  ? -divisor  : divisor;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                a_sh    = {a_q[BITS-1:0], q_q[BITS-1]};
                a_step  = a_q[BITS] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});
                a_d     = a_step;
                q_d     = {q_q[BITS-2:0], ~a_step[BITS]};
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (zero_q) begin
                    dbz_d    = 1'b1;
                    result_d = {{BITS{1'b1}}, q_q};
                end else begin
                    // Final remainder is below M, so the restore fits in BITS bits.
                    rem_mag  = a_q[BITS] ? (a_q[BITS-1:0] + m_q) : a_q[BITS-1:0];
                    quo      = (neg_n_q ^ neg_d_q) ? -q_q : q_q;
                    rem      = neg_n_q ? -rem_mag : rem_mag;
                    dbz_d    = 1'b0;
                    result_d = {quo, rem};
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            count_q  <= '0;
            neg_n_q  <= 1'b0;
            neg_d_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            m_q      <= m_d;
            count_q  <= count_d;
            neg_n_q  <= neg_n_d;
            neg_d_q  <= neg_d_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result      = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued at start and
// compared (value, zero flag, latency) when done pulses.
module tb_seq_divider;

    localparam int BITS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] result;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          start_edge;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    logic prev_done = 1'b0;

    seq_divider #(.BITS(BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic logic [64:0] model(input logic sm, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (sm) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, qq[31:0], rr[31:0]};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            check("done_pulse_width", {63'd0, prev_done}, 64'd0);
            if (sb_q.size() == 0) begin
                check("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", result, mon_e.res);
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
                check("latency", 64'(edge_cnt - mon_e.start_edge + 1), 64'(mon_e.lat));
            end
        end
        prev_done = done;
    end

    // Call just after a falling edge; start is sampled on the next rising edge.
    task automatic start_op(input logic sm, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] res, input logic dbz, input bit push);
        exp_t e;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        if (push) begin
            e.res        = res;
            e.dbz        = dbz;
            e.start_edge = edge_cnt + 1;
            e.lat        = (b == 32'd0) ? 2 : BITS + 2;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start       = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        signed_mode = ~sm;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_model(input logic sm, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] m;
        m = model(sm, a, b);
        start_op(sm, a, b, m[63:0], m[64], 1'b1);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        bit          seen;

        reset = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {63'd0, busy},        64'd0);
        check("rst_done",   {63'd0, done},        64'd0);
        check("rst_dbz",    {63'd0, div_by_zero}, 64'd0);
        check("rst_result", result,               64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 100 / 7 unsigned with per-cycle busy tracking
        start_op(1'b0, 32'd100, 32'd7, {32'd14, 32'd2}, 1'b0, 1'b1);
        check("busy_run", {63'd0, busy}, 64'd1);
        for (int k = 2; k <= 33; k++) begin
            @(negedge clk);
            check("busy_run", {63'd0, busy}, 64'd1);
        end
        @(negedge clk);
        check("busy_fall", {63'd0, busy}, 64'd0);
        check("done_edge34", {63'd0, done}, 64'd1);
        wait_drain();

        start_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1'b0, 1'b1);
        wait_drain();
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'h0000_0001}, 1'b0, 1'b1);
        wait_drain();
        start_op(1'b0, 32'hFFFF_FFFF, 32'd2, {32'h7FFF_FFFF, 32'h0000_0001}, 1'b0, 1'b1);
        wait_drain();
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 1'b0, 1'b1);
        wait_drain();
        start_op(1'b0, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'h0000_0005}, 1'b1, 1'b1);
        wait_drain();
        start_op(1'b1, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'h0000_0005}, 1'b1, 1'b1);
        wait_drain();
        start_op(1'b0, 32'hF000_0000, 32'hE000_0001, {32'h0000_0001, 32'h0FFF_FFFF}, 1'b0, 1'b1);
        wait_drain();

        // Start pulse on edge 10 while running must be ignored
        start_op(1'b0, 32'd1000, 32'd10, {32'd100, 32'd0}, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        start_op(1'b1, 32'd77, 32'd3, 64'd0, 1'b0, 1'b0);
        wait_drain();
        repeat (40) @(negedge clk);
        check("result_hold", result, {32'd100, 32'd0});

        start_op(1'b0, 32'd9, 32'd0, {32'hFFFF_FFFF, 32'h0000_0009}, 1'b1, 1'b1);
        wait_drain();

        // Reset on edge 20 of an in-flight divide
        start_op(1'b0, 32'd12345, 32'd6, 64'd0, 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy",   {63'd0, busy},        64'd0);
        check("abort_done",   {63'd0, done},        64'd0);
        check("abort_result", result,               64'd0);
        check("abort_dbz",    {63'd0, div_by_zero}, 64'd0);
        reset = 1'b0;
        repeat (50) @(negedge clk);

        // Back-to-back: second start issued in the done cycle of the first
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("b2b_first_done", {63'd0, seen}, 64'd1);
        start_op(1'b0, 32'd100, 32'd7, {32'd14, 32'd2}, 1'b0, 1'b1);
        wait_drain();

        for (int n = 0; n < 10; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            run_model(rs, ra, rb);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
